// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl: machine-mode interrupt/trap controller for the 5-stage RV32 pipeline.
// It takes NUM_IRQ sources. Each source is edge- or level-sensitive, and index 0 has the
// highest priority. The controller supports direct and vectored mtvec. It issues a
// registered flush/redirect at trap entry and at mret.
// Ports:
//   clk, rst                clock and asynchronous active-low reset
//   irq_i / irq_en_i        interrupt lines and per-source enables (mie)
//   gie_i                   global enable (mstatus.MIE)
//   mtvec_base_i/_mode_i    trap vector base (bits[1:0] ignored) and mode (1=vectored)
//   pc_mem_i, valid_mem_i   PC and valid flag of the instruction in MEM
//   mret_i                  mret retiring in MEM
//   flush_o, redirect_o     1-cycle pulses at trap entry and at handler exit
//   redirect_pc_o           redirect target while redirect_o=1, otherwise 0
//   mepc_o, mcause_o        captured return PC and cause {1, zero-pad, id}
//   pending_o               pending register
//   in_handler_o            high from entry until exit completes
module irq_trap_ctrl #(
    parameter int unsigned        NUM_IRQ   = 4,
    parameter int unsigned        XLEN      = 32,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               gie_i,
    input  logic [XLEN-1:0]    mtvec_base_i,
    input  logic               mtvec_mode_i,
    input  logic [XLEN-1:0]    pc_mem_i,
    input  logic               valid_mem_i,
    input  logic               mret_i,
    output logic               flush_o,
    output logic               redirect_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic [XLEN-1:0]    mcause_o,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic               in_handler_o
);

    localparam int unsigned ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int unsigned CAUSE_LO_W = XLEN - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_EXIT    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_IRQ-1:0]  pending_q, pending_d;
    logic [NUM_IRQ-1:0]  prev_q;
    logic [NUM_IRQ-1:0]  cand_c, clr_c, rise_c;
    logic [ID_W-1:0]     id_q, id_d, sel_id_c;
    logic                take_c;
    logic [XLEN-1:0]     vec_pc_c;
    logic [XLEN-1:0]     mepc_q, mepc_d;
    logic [XLEN-1:0]     mcause_q, mcause_d;
    logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
    logic                flush_q, flush_d;
    logic                in_handler_q, in_handler_d;

    // Fixed-priority pick: the lowest set index wins.
    always_comb begin
        sel_id_c = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand_c[i]) begin
                sel_id_c = ID_W'(i);
            end
        end
    end

    // An edge source stays pending until its ENTER cycle. A new edge in that cycle wins over the clear.
    always_comb begin
        clr_c     = (state_q == ST_ENTER) ? (NUM_IRQ'(1) << id_q) : '0;
        rise_c    = irq_i & ~prev_q;
        pending_d = (EDGE_MASK & ((pending_q & ~clr_c) | rise_c)) | (~EDGE_MASK & irq_i);
    end

    // Trap sequencing, next state and next values of the registered outputs.
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        flush_d       = 1'b0;
        redirect_pc_d = '0;
        in_handler_d  = 1'b0;

        cand_c   = pending_q & irq_en_i;
        take_c   = (state_q == ST_IDLE) && gie_i && valid_mem_i && (|cand_c);
        vec_pc_c = (mtvec_base_i & ~XLEN'(3))
                 + (mtvec_mode_i ? (XLEN'(sel_id_c) << 2) : '0);

        case (state_q)
            ST_IDLE: begin
                if (take_c) begin
                    state_d       = ST_ENTER;
                    id_d          = sel_id_c;
                    mepc_d        = pc_mem_i;
                    mcause_d      = {1'b1, CAUSE_LO_W'(sel_id_c)};
                    flush_d       = 1'b1;
                    redirect_pc_d = vec_pc_c;
                    in_handler_d  = 1'b1;
                end
            end
            ST_ENTER: begin
                state_d      = ST_HANDLER;
                in_handler_d = 1'b1;
            end
            ST_HANDLER: begin
                in_handler_d = 1'b1;
                if (mret_i) begin
                    state_d       = ST_EXIT;
                    flush_d       = 1'b1;
                    redirect_pc_d = mepc_q;
                end
            end
            ST_EXIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            prev_q        <= '0;
            id_q          <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            in_handler_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            prev_q        <= irq_i;
            id_q          <= id_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            in_handler_q  <= in_handler_d;
        end
    end

    assign flush_o       = flush_q;
    assign redirect_o    = flush_q;
    assign redirect_pc_o = redirect_pc_q;
    assign mepc_o        = mepc_q;
    assign mcause_o      = mcause_q;
    assign pending_o     = pending_q;
    assign in_handler_o  = in_handler_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Testbench for irq_trap_ctrl. A behavioural reference model predicts each flush/redirect
// event and pushes it into a queue. A negedge monitor pops each event and compares it with
// the DUT. Directed scenarios run first, then randomized traffic.
module tb_irq_trap_ctrl;

    localparam logic [3:0] EDGE = 4'b0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  irq, irq_en;
    logic        gie, mtvec_mode, valid_mem, mret;
    logic [31:0] mtvec_base, pc_mem;
    logic        flush_o, redirect_o, in_handler_o;
    logic [31:0] redirect_pc_o, mepc_o, mcause_o;
    logic [3:0]  pending_o;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    irq_trap_ctrl #(
        .NUM_IRQ   (4),
        .XLEN      (32),
        .EDGE_MASK (EDGE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_i         (irq),
        .irq_en_i      (irq_en),
        .gie_i         (gie),
        .mtvec_base_i  (mtvec_base),
        .mtvec_mode_i  (mtvec_mode),
        .pc_mem_i      (pc_mem),
        .valid_mem_i   (valid_mem),
        .mret_i        (mret),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .mepc_o        (mepc_o),
        .mcause_o      (mcause_o),
        .pending_o     (pending_o),
        .in_handler_o  (in_handler_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mepc;
        logic [31:0] mcause;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model. It follows the interrupt rules at the level of the whole trap:
    // "not busy" / "entering" / "in handler" / "exiting".
    logic [3:0]  m_pend, m_prev, m_cand, m_np;
    logic [31:0] m_mepc, m_mcause, m_tgt;
    bit          m_active, m_enter, m_exit;
    int          m_id;
    logic [3:0]  exp_pend;
    bit          exp_ih;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = '0; m_prev = '0; m_active = 0; m_enter = 0; m_exit = 0;
            m_id = 0; m_mepc = '0; m_mcause = '0;
            exp_q.delete();
        end else begin
            m_cand = m_pend & irq_en;
            for (int i = 0; i < 4; i++) begin
                if (EDGE[i])
                    m_np[i] = (m_pend[i] && !(m_enter && m_id == i)) || (irq[i] && !m_prev[i]);
                else
                    m_np[i] = irq[i];
            end
            if (!m_active) begin
                if (gie && valid_mem && (m_cand != 4'b0)) begin
                    for (int i = 3; i >= 0; i--) if (m_cand[i]) m_id = i;
                    m_mepc   = pc_mem;
                    m_mcause = 32'h8000_0000 | 32'(m_id);
                    m_tgt    = (mtvec_base & ~32'd3) + (mtvec_mode ? 32'(m_id * 4) : 32'd0);
                    exp_q.push_back('{m_tgt, m_mepc, m_mcause});
                    m_active = 1;
                    m_enter  = 1;
                end
            end else if (m_enter) begin
                m_enter = 0;
            end else if (m_exit) begin
                m_exit   = 0;
                m_active = 0;
            end else if (mret) begin
                m_exit = 1;
                exp_q.push_back('{m_mepc, m_mepc, m_mcause});
            end
            m_pend = m_np;
            m_prev = irq;
        end
        exp_pend = m_pend;
        exp_ih   = m_active;
    end

    // Monitor: compares every cycle and consumes predicted events whenever the DUT pulses.
    always @(negedge clk) begin
        if (rst) begin
            chk("pending", 32'(pending_o), 32'(exp_pend));
            chk("in_handler", 32'(in_handler_o), 32'(exp_ih));
            chk("redirect_eq_flush", 32'(redirect_o), 32'(flush_o));
            if (flush_o) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_flush: got flush=1 expected flush=0");
                end else begin
                    mon_ev = exp_q.pop_front();
                    chk("redirect_pc", redirect_pc_o, mon_ev.pc);
                    chk("mepc", mepc_o, mon_ev.mepc);
                    chk("mcause", mcause_o, mon_ev.mcause);
                end
            end else begin
                chk("redirect_pc_idle", redirect_pc_o, 32'd0);
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    vectors++;
                    miscompares++;
                    $display("FAIL missed_flush: got flush=0 expected flush=1");
                end
            end
        end
    end

    task automatic expect_flush(output int k);
        k = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            k = n;
            if (flush_o) break;
            if (n == 10) k = 11;
        end
    endtask

    task automatic do_mret(input logic [31:0] ret_pc);
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
        chk("exit_flush", 32'(flush_o), 32'd1);
        chk("exit_pc", redirect_pc_o, ret_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        irq = '0; irq_en = '0; gie = 0; valid_mem = 0; mret = 0;
        pc_mem = '0; mtvec_base = '0; mtvec_mode = 0;

        // Reset with all lines high, then release.
        irq = 4'hF;
        repeat (2) @(negedge clk);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_redirect_pc", redirect_pc_o, 32'd0);
        chk("rst_mepc", mepc_o, 32'd0);
        chk("rst_mcause", mcause_o, 32'd0);
        chk("rst_pending", 32'(pending_o), 32'd0);
        chk("rst_in_handler", 32'(in_handler_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_pending", 32'(pending_o), 32'hF);
        rst = 1'b0; irq = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Direct mode, edge source 2.
        irq_en = 4'hF; gie = 1; valid_mem = 1; pc_mem = 32'h100;
        mtvec_base = 32'h8000; mtvec_mode = 0; irq = 4'b0100;
        expect_flush(k);
        chk("edge_latency", k, 32'd2);
        chk("d_redirect_pc", redirect_pc_o, 32'h8000);
        chk("d_mepc", mepc_o, 32'h100);
        chk("d_mcause", mcause_o, 32'h8000_0002);
        @(negedge clk);
        chk("edge_pend_clear", 32'(pending_o), 32'd0);
        irq = '0;
        do_mret(32'h100);
        @(negedge clk);
        chk("idle_in_handler", 32'(in_handler_o), 32'd0);

        // Vectored mode, two level sources together.
        mtvec_base = 32'h8001; mtvec_mode = 1; irq = 4'b1010;
        expect_flush(k);
        chk("level_latency", k, 32'd2);
        chk("v_redirect_pc", redirect_pc_o, 32'h8004);
        chk("v_mcause", mcause_o, 32'h8000_0001);

        // A request during the handler only pends. Re-entry follows the exit.
        irq = 4'b1011;
        repeat (3) begin
            @(negedge clk);
            chk("no_nest_flush", 32'(flush_o), 32'd0);
        end
        chk("nest_pending", 32'(pending_o), 32'hB);
        do_mret(32'h100);
        expect_flush(k);
        chk("reentry_latency", k, 32'd2);
        chk("reentry_mcause", mcause_o, 32'h8000_0000);
        irq = '0;
        @(negedge clk);
        do_mret(32'h100);
        @(negedge clk);

        // Gated by gie, then gated by a bubble in MEM.
        mtvec_mode = 0; mtvec_base = 32'h8000; gie = 0; irq = 4'b0010;
        repeat (3) begin
            @(negedge clk);
            chk("gie_gate", 32'(flush_o), 32'd0);
        end
        gie = 1; pc_mem = 32'h200;
        @(negedge clk);
        chk("gie_entry", 32'(flush_o), 32'd1);
        chk("gie_mepc", mepc_o, 32'h200);
        @(negedge clk);
        valid_mem = 0;
        do_mret(32'h200);
        repeat (3) begin
            @(negedge clk);
            chk("bubble_gate", 32'(flush_o), 32'd0);
        end
        valid_mem = 1; pc_mem = 32'h300;
        @(negedge clk);
        chk("bubble_entry", 32'(flush_o), 32'd1);
        chk("bubble_mepc", mepc_o, 32'h300);
        irq = '0;
        @(negedge clk);
        do_mret(32'h300);
        @(negedge clk);

        // Reset asserted in the middle of ENTER.
        irq = 4'b1000;
        expect_flush(k);
        chk("pre_rst_flush", 32'(flush_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_flush", 32'(flush_o), 32'd0);
        chk("mid_rst_redirect", 32'(redirect_o), 32'd0);
        chk("mid_rst_in_handler", 32'(in_handler_o), 32'd0);
        @(negedge clk);
        irq = '0; rst = 1'b1;
        @(negedge clk);
        chk("after_rst_mepc", mepc_o, 32'd0);
        chk("after_rst_mcause", mcause_o, 32'd0);
        chk("after_rst_in_handler", 32'(in_handler_o), 32'd0);

        // Randomized traffic, including wrap-around bases and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
            if ($urandom_range(0, 7) == 0) irq_en = 4'($urandom);
            gie        = ($urandom_range(0, 9) != 0);
            valid_mem  = ($urandom_range(0, 4) != 0);
            mret       = ($urandom_range(0, 5) == 0);
            pc_mem     = $urandom;
            mtvec_base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            mtvec_mode = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1'b1; mret = 0; irq = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
